// File: rtl/se_arbiter.sv
// se_arbiter: shares one speaker tone path between N_SRC sound-effect players.
// Requests are latched, granted one at a time by fixed priority (index 0 highest),
// and the owner's enable/frequency is forwarded with one cycle of latency.
// A silent gap separates consecutive effects.
// Optional feature macro: SE_PREEMPT_EN. When it is defined, a pending higher-priority
// request aborts the current owner. When it is undefined, oStop is always 0.
module se_arbiter #(
    parameter int unsigned N_SRC         = 4,
    parameter int unsigned GAP_CYCLES    = 5000,
    parameter int unsigned START_TIMEOUT = 16,
    localparam int unsigned OW           = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                iClock,
    input  logic                iReset,
    input  logic [N_SRC-1:0]    iReq,
    output logic [N_SRC-1:0]    oTrig,
    output logic [N_SRC-1:0]    oStop,
    input  logic [N_SRC-1:0]    iBusy,
    input  logic [16*N_SRC-1:0] iFreq,
    output logic                oEnable,
    output logic [15:0]         oFreq,
    output logic [OW-1:0]       oOwner
);

    // A zero gap or timeout would never terminate the counter compare.
    localparam int unsigned GapEff   = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned StartEff = (START_TIMEOUT == 0) ? 1 : START_TIMEOUT;
    localparam int unsigned TMax     = (GapEff > StartEff) ? GapEff : StartEff;
    localparam int unsigned TW       = $clog2(TMax + 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StPlay,
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [N_SRC-1:0]   pending_q, pending_d;
    logic [N_SRC-1:0]   trig_q, trig_d;
    logic [N_SRC-1:0]   stop_q, stop_d;
    logic               enable_q, enable_d;
    logic [15:0]        freq_q, freq_d;

    logic               active;
    logic [N_SRC-1:0]   owner_oh;
    logic [N_SRC-1:0]   pend_in;
    logic               grant_vld;
    logic [OW-1:0]      grant_idx;
    logic [N_SRC-1:0]   grant_oh;
    logic               own_busy;
    logic [15:0]        own_freq;
    logic               preempt;

    // Decode owner, merge this cycle's requests and pick the lowest pending index.
    always_comb begin
        active   = (state_q == StStart) || (state_q == StPlay);
        owner_oh = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (owner_q == OW'(k)) begin
                owner_oh[k] = 1'b1;
            end
        end
        // A re-request from the source already being served is dropped.
        pend_in   = pending_q | (iReq & ~(active ? owner_oh : '0));
        grant_vld = |pend_in;
        grant_idx = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (pend_in[k]) begin
                grant_idx = OW'(k);
            end
        end
        // Isolate the lowest set bit.
        grant_oh = pend_in & (~pend_in + N_SRC'(1));
        own_busy = |(iBusy & owner_oh);
        own_freq = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (owner_oh[k]) begin
                own_freq = iFreq[16*k +: 16];
            end
        end
    end

`ifdef SE_PREEMPT_EN
    logic [N_SRC-1:0] hi_mask;
    // Pending sources with a lower index than the owner abort the current effect.
    always_comb begin
        hi_mask = owner_oh - N_SRC'(1);
        preempt = active && |(pending_q & hi_mask);
    end
`else
    assign preempt = 1'b0;
`endif

    // State register with synchronous reset; reset does not stop the player itself.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            owner_q   <= '0;
            pending_q <= '0;
            trig_q    <= '0;
            stop_q    <= '0;
            enable_q  <= 1'b0;
            freq_q    <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            owner_q   <= owner_d;
            pending_q <= pending_d;
            trig_q    <= trig_d;
            stop_q    <= stop_d;
            enable_q  <= enable_d;
            freq_q    <= freq_d;
        end
    end

    // Next-state logic: grant, start timeout, play tracking and silent gap.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        owner_d   = owner_q;
        pending_d = pend_in;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    owner_d   = grant_idx;
                    pending_d = pend_in & ~grant_oh;
                    timer_d   = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (preempt) begin
                    timer_d = '0;
                    state_d = StGap;
                end else if (own_busy) begin
                    state_d = StPlay;
                end else if (timer_q == TW'(StartEff - 1)) begin
                    // Player never answered; abandon the grant without retry.
                    timer_d = '0;
                    state_d = StGap;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StPlay: begin
                if (preempt || !own_busy) begin
                    timer_d = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (timer_q == TW'(GapEff - 1)) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Registered outputs: trigger on grant, stop on preempt, forward owner tone.
    always_comb begin
        trig_d   = '0;
        stop_d   = '0;
        enable_d = 1'b0;
        freq_d   = '0;
        if ((state_q == StIdle) && grant_vld) begin
            trig_d = grant_oh;
        end
        if (preempt) begin
            stop_d = owner_oh;
        end else if (active && own_busy) begin
            // Covers the START->PLAY edge so the tone starts one cycle after busy.
            enable_d = 1'b1;
            freq_d   = own_freq;
        end
    end

    assign oTrig   = trig_q;
    assign oStop   = stop_q;
    assign oEnable = enable_q;
    assign oFreq   = freq_q;
    assign oOwner  = owner_q;

endmodule

// File: tb/tb_se_arbiter.sv
// Directed bench for se_arbiter (default build, SE_PREEMPT_EN undefined).
module tb_se_arbiter;

    localparam int unsigned NS  = 4;
    localparam int unsigned GAP = 5000;
    localparam int unsigned TO  = 16;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [3:0]  iReq;
    logic [3:0]  oTrig;
    logic [3:0]  oStop;
    logic [3:0]  iBusy;
    logic [63:0] iFreq;
    logic        oEnable;
    logic [15:0] oFreq;
    logic [1:0]  oOwner;

    always #5 iClock = ~iClock;

    se_arbiter #(
        .N_SRC         (NS),
        .GAP_CYCLES    (GAP),
        .START_TIMEOUT (TO)
    ) dut (
        .iClock  (iClock),
        .iReset  (iReset),
        .iReq    (iReq),
        .oTrig   (oTrig),
        .oStop   (oStop),
        .iBusy   (iBusy),
        .iFreq   (iFreq),
        .oEnable (oEnable),
        .oFreq   (oFreq),
        .oOwner  (oOwner)
    );

    typedef struct packed {
        logic [3:0] trig;
        logic [1:0] owner;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   stop_seen = 0;

    always @(negedge iClock) begin
        if (oStop != 4'b0000) stop_seen++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge iClock);
    endtask

    task automatic push_exp(input logic [3:0] t, input logic [1:0] o);
        exp_t e;
        e.trig  = t;
        e.owner = o;
        exp_q.push_back(e);
    endtask

    // One-cycle request pulse, seen by exactly one rising edge.
    task automatic pulse_req(input logic [3:0] r);
        iReq = r;
        @(posedge iClock);
        #1 iReq = 4'b0000;
    endtask

    // Wait for the next trigger and compare it against the scoreboard head.
    task automatic wait_trig(input string tag, input int budget, output int n_o,
                             output int en_o);
        int   n  = 0;
        int   en = 0;
        exp_t e;
        do begin
            @(negedge iClock);
            n++;
            if (oEnable === 1'b1) en = 1;
        end while (oTrig == 4'b0000 && n < budget);
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_trig"}, int'(oTrig), 0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_trig"}, int'(oTrig), int'(e.trig));
            chk({tag, "_owner"}, int'(oOwner), int'(e.owner));
        end
        n_o  = n;
        en_o = en;
    endtask

    initial begin
        int n;
        int en;
        int bad;

        iReset = 1'b1;
        iReq   = '0;
        iBusy  = '0;
        iFreq  = '0;
        cyc(3);
        iReset = 1'b0;
        chk("rst_trig", int'(oTrig), 0);
        chk("rst_stop", int'(oStop), 0);
        chk("rst_enable", int'(oEnable), 0);
        chk("rst_freq", int'(oFreq), 0);
        chk("rst_owner", int'(oOwner), 0);

        // Basic play on source 2.
        push_exp(4'b0100, 2'd2);
        pulse_req(4'b0100);
        wait_trig("basic", 20, n, en);
        chk("basic_trig_lat", n, 1);
        iFreq[47:32] = 16'd1300;
        iBusy        = 4'b0100;
        cyc(1);
        chk("basic_trig_once", int'(oTrig), 0);
        chk("basic_enable", int'(oEnable), 1);
        chk("basic_freq", int'(oFreq), 1300);
        bad = 0;
        repeat (98) begin
            @(negedge iClock);
            if (oEnable !== 1'b1 || oFreq !== 16'd1300 || oOwner !== 2'd2) bad++;
        end
        chk("basic_hold", bad, 0);
        iBusy = 4'b0000;
        cyc(1);
        chk("basic_off_enable", int'(oEnable), 0);
        chk("basic_off_freq", int'(oFreq), 0);
        cyc(2500);
        chk("basic_gap_owner", int'(oOwner), 2);
        cyc(2510);

        // Priority: sources 1 and 3 together, 1 wins.
        push_exp(4'b0010, 2'd1);
        push_exp(4'b1000, 2'd3);
        pulse_req(4'b1010);
        wait_trig("prio1", 20, n, en);
        chk("prio1_lat", n, 1);
        iFreq[31:16] = 16'd777;
        iFreq[63:48] = 16'd3000;
        iBusy        = 4'b0010;
        cyc(10);
        chk("prio1_freq", int'(oFreq), 777);
        iBusy = 4'b0000;
        cyc(1);
        chk("prio1_off", int'(oEnable), 0);
        chk("prio1_gap_owner", int'(oOwner), 1);
        wait_trig("prio3", 6000, n, en);
        chk("prio3_gap_len", n, GAP + 1);
        iBusy = 4'b1000;
        cyc(1);
        chk("prio3_freq", int'(oFreq), 3000);
        cyc(4);
        iBusy = 4'b0000;
        cyc(5010);

        // Start timeout on source 0; a request for 1 during START waits it out.
        push_exp(4'b0001, 2'd0);
        pulse_req(4'b0001);
        wait_trig("tmo0", 20, n, en);
        chk("tmo0_lat", n, 1);
        push_exp(4'b0010, 2'd1);
        pulse_req(4'b0010);
        wait_trig("tmo1", 6000, n, en);
        chk("tmo_len", n, TO + GAP + 1);
        chk("tmo_no_enable", en, 0);
        cyc(5030);

        // Filtering: a re-request from the playing source is dropped.
        push_exp(4'b0100, 2'd2);
        pulse_req(4'b0100);
        wait_trig("filt2", 20, n, en);
        iFreq[47:32] = 16'd2000;
        iBusy        = 4'b0100;
        cyc(3);
        push_exp(4'b1000, 2'd3);
        pulse_req(4'b1100);
        @(negedge iClock);
        chk("filt2_freq", int'(oFreq), 2000);
        iBusy = 4'b0000;
        cyc(1);
        wait_trig("filt3", 6000, n, en);
        chk("filt3_gap_len", n, GAP + 1);
        bad = 0;
        repeat (5040) begin
            @(negedge iClock);
            if (oTrig != 4'b0000) bad++;
        end
        chk("filt_no_replay", bad, 0);

        // Higher-priority request while 3 plays: no preemption in this build.
        push_exp(4'b1000, 2'd3);
        pulse_req(4'b1000);
        wait_trig("pre3", 20, n, en);
        iFreq[63:48] = 16'd3333;
        iBusy        = 4'b1000;
        cyc(3);
        push_exp(4'b0001, 2'd0);
        pulse_req(4'b0001);
        cyc(20);
        chk("pre3_enable", int'(oEnable), 1);
        chk("pre3_freq", int'(oFreq), 3333);
        chk("pre3_owner", int'(oOwner), 3);
        iBusy = 4'b0000;
        cyc(1);
        wait_trig("pre0", 6000, n, en);
        chk("pre0_gap_len", n, GAP + 1);
        iFreq[15:0] = 16'd500;
        iBusy       = 4'b0001;
        cyc(3);
        chk("pre0_freq", int'(oFreq), 500);
        iBusy = 4'b0000;
        cyc(5010);

        // Reset during PLAY with sources 0 and 1 pending.
        push_exp(4'b0100, 2'd2);
        pulse_req(4'b0100);
        wait_trig("mrst2", 20, n, en);
        iBusy = 4'b0100;
        cyc(3);
        pulse_req(4'b0011);
        iReset = 1'b1;
        @(posedge iClock);
        #1 iReset = 1'b0;
        @(negedge iClock);
        chk("mrst_enable", int'(oEnable), 0);
        chk("mrst_freq", int'(oFreq), 0);
        chk("mrst_owner", int'(oOwner), 0);
        bad = 0;
        repeat (50) begin
            @(negedge iClock);
            if (oTrig != 4'b0000 || oEnable !== 1'b0) bad++;
        end
        chk("mrst_quiet", bad, 0);
        iBusy = 4'b0000;
        push_exp(4'b0010, 2'd1);
        pulse_req(4'b0010);
        wait_trig("mrst1", 20, n, en);
        chk("mrst1_lat", n, 1);

        chk("stop_never", stop_seen, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
